// File: rtl/rf_wb_scheduler.sv
// Register-file writeback scheduler: arbitrates ALU/load writebacks onto one registered write port,
// 1-cycle latency, ready-based backpressure (alternating priority on conflict); tracks busy destinations.
module rf_wb_scheduler #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            alu_valid,
   input  logic [AW-1:0]   alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            mem_valid,
   input  logic [AW-1:0]   mem_rd,
   input  logic [XLEN-1:0] mem_data,
   output logic            mem_ready,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            rd_busy,
   output logic            reg_write,
   output logic [AW-1:0]   rd_addr,
   output logic [XLEN-1:0] wb_data
);

   logic             prio_alu_q, prio_alu_d;
   logic             reg_write_q, reg_write_d;
   logic [AW-1:0]    rd_addr_q, rd_addr_d;
   logic [XLEN-1:0]  wb_data_q, wb_data_d;
   logic [NREGS-1:0] busy_q, busy_d;

   assign alu_ready = alu_valid & (~mem_valid | prio_alu_q);
   assign mem_ready = mem_valid & (~alu_valid | ~prio_alu_q);

   // Priority only moves on a conflict, handing the next cycle to the loser.
   always_comb begin
      prio_alu_d = prio_alu_q;
      if (alu_valid && mem_valid) begin
         prio_alu_d = ~prio_alu_q;
      end
   end

   // Writes to x0 are accepted but never reach the register file.
   always_comb begin
      reg_write_d = 1'b0;
      rd_addr_d   = rd_addr_q;
      wb_data_d   = wb_data_q;
      if (alu_ready && alu_rd != '0) begin
         reg_write_d = 1'b1;
         rd_addr_d   = alu_rd;
         wb_data_d   = alu_data;
      end else if (mem_ready && mem_rd != '0) begin
         reg_write_d = 1'b1;
         rd_addr_d   = mem_rd;
         wb_data_d   = mem_data;
      end
   end

   // Set is applied after clear so a new producer issued on the commit edge stays outstanding.
   always_comb begin
      busy_d = busy_q;
      if (reg_write_q) begin
         busy_d[rd_addr_q] = 1'b0;
      end
      if (issue_valid) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_alu_q  <= 1'b0;
         reg_write_q <= 1'b0;
         rd_addr_q   <= '0;
         wb_data_q   <= '0;
         busy_q      <= '0;
      end else begin
         prio_alu_q  <= prio_alu_d;
         reg_write_q <= reg_write_d;
         rd_addr_q   <= rd_addr_d;
         wb_data_q   <= wb_data_d;
         busy_q      <= busy_d;
      end
   end

   assign reg_write = reg_write_q;
   assign rd_addr   = rd_addr_q;
   assign wb_data   = wb_data_q;
   assign rs1_busy  = busy_q[rs1_addr];
   assign rs2_busy  = busy_q[rs2_addr];
   assign rd_busy   = busy_q[issue_rd];

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Bench for rf_wb_scheduler: directed scenarios plus randomized traffic against a behavioural model.
module tb_rf_wb_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, mem_valid, issue_valid;
   logic [4:0]  alu_rd, mem_rd, issue_rd, rs1_addr, rs2_addr;
   logic [31:0] alu_data, mem_data;
   logic        alu_ready, mem_ready, rs1_busy, rs2_busy, rd_busy;
   logic        reg_write;
   logic [4:0]  rd_addr;
   logic [31:0] wb_data;

   int total = 0;
   int bad   = 0;

   // Behavioural model: who has priority, which registers await a write, the pending write-port content.
   bit          m_prio_alu;
   bit [31:0]   m_busy;
   bit          m_wr;
   bit [4:0]    m_rd;
   bit [31:0]   m_data;

   rf_wb_scheduler dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
      .reg_write(reg_write), .rd_addr(rd_addr), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   function automatic bit exp_alu_grant();
      return alu_valid && (!mem_valid || m_prio_alu);
   endfunction

   function automatic bit exp_mem_grant();
      return mem_valid && (!alu_valid || !m_prio_alu);
   endfunction

   task automatic model_reset();
      m_prio_alu = 1'b0;
      m_busy     = '0;
      m_wr       = 1'b0;
      m_rd       = '0;
      m_data     = '0;
   endtask

   task automatic model_edge();
      bit ga, gm;
      ga = exp_alu_grant();
      gm = exp_mem_grant();
      if (m_wr) m_busy[m_rd] = 1'b0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (alu_valid && mem_valid) m_prio_alu = !ga;
      m_wr = 1'b0;
      if (ga && alu_rd != 0) begin
         m_wr = 1'b1; m_rd = alu_rd; m_data = alu_data;
      end else if (gm && mem_rd != 0) begin
         m_wr = 1'b1; m_rd = mem_rd; m_data = mem_data;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bit any_busy;
      issue_valid = 1; issue_rd = 6; alu_valid = 1; alu_rd = 5; alu_data = 32'h1234_5678;
      #1;
      tick();
      issue_valid = 0; alu_valid = 0;
      #1;
      total++;
      if (reg_write !== 1'b1) begin bad++; $display("FAIL reset_pre_write got=%b want=1", reg_write); end
      reset = 1;
      #1;
      total++;
      if (reg_write !== 1'b0 || rd_addr !== 5'd0 || wb_data !== 32'd0) begin
         bad++; $display("FAIL reset_outputs got=%b/%0d/%h want=0/0/0", reg_write, rd_addr, wb_data);
      end
      any_busy = 0;
      for (int r = 0; r < 32; r++) begin
         rs1_addr = 5'(r);
         #1;
         if (rs1_busy !== 1'b0) any_busy = 1;
      end
      total++;
      if (any_busy) begin bad++; $display("FAIL reset_busy got=some_busy want=all_clear"); end
      @(posedge clk);
      #1;
      reset = 0;
      model_reset();
      alu_valid = 1; mem_valid = 1; alu_rd = 1; mem_rd = 2;
      #1;
      total++;
      if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
         bad++; $display("FAIL reset_prio got=alu%b/mem%b want=alu0/mem1", alu_ready, mem_ready);
      end
      alu_valid = 0; mem_valid = 0;
      #1;
   endtask

   task automatic test_single_alu();
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF;
      #1;
      total++;
      if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
         bad++; $display("FAIL single_ready got=alu%b/mem%b want=alu1/mem0", alu_ready, mem_ready);
      end
      tick();
      alu_valid = 0;
      total++;
      if (reg_write !== 1'b1 || rd_addr !== 5'd5 || wb_data !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL single_write got=%b/%0d/%h want=1/5/deadbeef", reg_write, rd_addr, wb_data);
      end
      #1;
      tick();
      total++;
      if (reg_write !== 1'b0 || rd_addr !== 5'd5 || wb_data !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL idle_hold got=%b/%0d/%h want=0/5/deadbeef", reg_write, rd_addr, wb_data);
      end
   endtask

   task automatic test_conflict();
      alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
      mem_valid = 1; mem_rd = 4; mem_data = 32'h22;
      #1;
      total++;
      if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
         bad++; $display("FAIL conflict_c0 got=alu%b/mem%b want=alu0/mem1", alu_ready, mem_ready);
      end
      tick();
      mem_valid = 0;
      #1;
      total++;
      if (alu_ready !== 1'b1) begin bad++; $display("FAIL conflict_c1 got=alu%b want=alu1", alu_ready); end
      total++;
      if (reg_write !== 1'b1 || rd_addr !== 5'd4 || wb_data !== 32'h22) begin
         bad++; $display("FAIL conflict_w0 got=%b/%0d/%h want=1/4/22", reg_write, rd_addr, wb_data);
      end
      tick();
      alu_valid = 0;
      total++;
      if (reg_write !== 1'b1 || rd_addr !== 5'd3 || wb_data !== 32'h11) begin
         bad++; $display("FAIL conflict_w1 got=%b/%0d/%h want=1/3/11", reg_write, rd_addr, wb_data);
      end
      #1;
   endtask

   task automatic test_fairness();
      bit last_alu, first;
      first = 1;
      alu_valid = 1; mem_valid = 1;
      alu_rd = 5'($urandom_range(31, 1)); alu_data = $urandom;
      mem_rd = 5'($urandom_range(31, 1)); mem_data = $urandom;
      for (int i = 0; i < 8; i++) begin
         #1;
         total++;
         if ((alu_ready ^ mem_ready) !== 1'b1 || alu_ready !== exp_alu_grant()) begin
            bad++; $display("FAIL fair_grant cyc=%0d got=alu%b/mem%b want_alu=%b", i, alu_ready, mem_ready, exp_alu_grant());
         end
         if (!first) begin
            total++;
            if (alu_ready === last_alu) begin
               bad++; $display("FAIL fair_alternate cyc=%0d got=alu%b want=alu%b", i, alu_ready, !last_alu);
            end
         end
         first = 0;
         last_alu = alu_ready;
         tick();
         total++;
         if (reg_write !== 1'b1 || rd_addr !== m_rd || wb_data !== m_data) begin
            bad++; $display("FAIL fair_write cyc=%0d got=%b/%0d/%h want=1/%0d/%h", i, reg_write, rd_addr, wb_data, m_rd, m_data);
         end
         if (last_alu) begin alu_rd = 5'($urandom_range(31, 1)); alu_data = $urandom; end
         else begin mem_rd = 5'($urandom_range(31, 1)); mem_data = $urandom; end
      end
      alu_valid = 0; mem_valid = 0;
      #1;
      tick();
   endtask

   task automatic test_scoreboard();
      issue_valid = 1; issue_rd = 7; rs1_addr = 7; rs2_addr = 7;
      #1;
      total++;
      if (rs1_busy !== 1'b0) begin bad++; $display("FAIL sb_before got=%b want=0", rs1_busy); end
      tick();
      issue_valid = 0;
      #1;
      total++;
      if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
         bad++; $display("FAIL sb_set got=%b/%b want=1/1", rs1_busy, rs2_busy);
      end
      mem_valid = 1; mem_rd = 7; mem_data = 32'hCAFE_0007;
      #1;
      tick();
      mem_valid = 0;
      #1;
      total++;
      if (reg_write !== 1'b1 || rd_addr !== 5'd7 || rs1_busy !== 1'b1) begin
         bad++; $display("FAIL sb_nobypass got=wr%b/rd%0d/busy%b want=wr1/rd7/busy1", reg_write, rd_addr, rs1_busy);
      end
      tick();
      total++;
      if (rs1_busy !== 1'b0) begin bad++; $display("FAIL sb_clear got=%b want=0", rs1_busy); end
   endtask

   task automatic test_edges();
      issue_valid = 1; issue_rd = 9;
      #1;
      tick();
      issue_valid = 0;
      alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
      #1;
      tick();
      alu_valid = 0;
      issue_valid = 1; issue_rd = 9;
      #1;
      total++;
      if (reg_write !== 1'b1 || rd_busy !== 1'b1) begin
         bad++; $display("FAIL edge_waw got=wr%b/busy%b want=wr1/busy1", reg_write, rd_busy);
      end
      tick();
      issue_valid = 0; rs1_addr = 9;
      #1;
      total++;
      if (rs1_busy !== 1'b1) begin bad++; $display("FAIL edge_set_wins got=%b want=1", rs1_busy); end
      issue_valid = 1; issue_rd = 0;
      #1;
      tick();
      rs1_addr = 0;
      #1;
      total++;
      if (rs1_busy !== 1'b0 || rd_busy !== 1'b0) begin
         bad++; $display("FAIL edge_x0_busy got=%b/%b want=0/0", rs1_busy, rd_busy);
      end
      issue_valid = 0;
      alu_valid = 1; alu_rd = 0; alu_data = 32'hBAD0;
      #1;
      total++;
      if (alu_ready !== 1'b1) begin bad++; $display("FAIL edge_x0_ready got=%b want=1", alu_ready); end
      tick();
      alu_valid = 0;
      total++;
      if (reg_write !== 1'b0) begin bad++; $display("FAIL edge_x0_write got=%b want=0", reg_write); end
      #1;
   endtask

   task automatic test_random();
      int alu_wait, mem_wait;
      bit ga, gm;
      alu_wait = 0; mem_wait = 0;
      for (int i = 0; i < 400; i++) begin
         if (!alu_valid && $urandom_range(1, 0) == 1) begin
            alu_valid = 1; alu_rd = 5'($urandom_range(7, 0)); alu_data = $urandom;
         end
         if (!mem_valid && $urandom_range(1, 0) == 1) begin
            mem_valid = 1; mem_rd = 5'($urandom_range(7, 0)); mem_data = $urandom;
         end
         issue_valid = ($urandom_range(2, 0) == 0);
         issue_rd = 5'($urandom_range(7, 0));
         rs1_addr = 5'($urandom_range(7, 0));
         rs2_addr = 5'($urandom_range(7, 0));
         #1;
         ga = exp_alu_grant();
         gm = exp_mem_grant();
         total++;
         if (alu_ready !== ga || mem_ready !== gm) begin
            bad++; $display("FAIL rnd_ready cyc=%0d got=alu%b/mem%b want=alu%b/mem%b", i, alu_ready, mem_ready, ga, gm);
         end
         total++;
         if (rs1_busy !== m_busy[rs1_addr] || rs2_busy !== m_busy[rs2_addr] || rd_busy !== m_busy[issue_rd]) begin
            bad++; $display("FAIL rnd_busy cyc=%0d got=%b%b%b want=%b%b%b", i, rs1_busy, rs2_busy, rd_busy,
                            m_busy[rs1_addr], m_busy[rs2_addr], m_busy[issue_rd]);
         end
         alu_wait = (alu_valid && !ga) ? alu_wait + 1 : 0;
         mem_wait = (mem_valid && !gm) ? mem_wait + 1 : 0;
         total++;
         if (alu_wait > 1 || mem_wait > 1) begin
            bad++; $display("FAIL rnd_starve cyc=%0d got=%0d/%0d want<=1", i, alu_wait, mem_wait);
         end
         tick();
         if (ga) alu_valid = 0;
         if (gm) mem_valid = 0;
         total++;
         if (reg_write !== m_wr || (m_wr && (rd_addr !== m_rd || wb_data !== m_data))) begin
            bad++; $display("FAIL rnd_write cyc=%0d got=%b/%0d/%h want=%b/%0d/%h", i, reg_write, rd_addr, wb_data, m_wr, m_rd, m_data);
         end
      end
      alu_valid = 0; mem_valid = 0; issue_valid = 0;
      #1;
   endtask

   initial begin
      reset = 1;
      alu_valid = 0; mem_valid = 0; issue_valid = 0;
      alu_rd = 0; mem_rd = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
      alu_data = 0; mem_data = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      test_reset();
      test_single_alu();
      test_conflict();
      test_fairness();
      test_scoreboard();
      test_edges();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
